// File: rtl/decoder_2nrm_if.sv
// Request/result bundle for the 2-NRM residue decoder.
// The requester drives start and the packed codeword; the decoder returns
// the reconstructed value, per-modulus mismatch flags and status.
interface decoder_2nrm_if;
  logic        start;
  logic [63:0] residues_in;
  logic [15:0] data_out;
  logic [3:0]  mismatch_mask;
  logic        range_err;
  logic        err_detected;
  logic        done;
  logic        busy;

  modport master (
    output start, residues_in,
    input  data_out, mismatch_mask, range_err, err_detected, done, busy
  );

  modport slave (
    input  start, residues_in,
    output data_out, mismatch_mask, range_err, err_detected, done, busy
  );
endinterface

// File: rtl/decoder_2nrm.sv
// 2-NRM residue decoder with error detection.
// The value is rebuilt from the (257, 256) residue pair by a one-cycle CRT,
// then re-reduced against the four redundant moduli with one bit-serial
// restoring divider (17 steps per modulus). Any disagreement with the
// received redundant residues flags an error; nothing is corrected.
module decoder_2nrm (
  input  logic           clk,
  input  logic           rst_n,
  decoder_2nrm_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CRT, CHECK, OUT} state_t;

  state_t      state_q, state_d;
  logic [40:0] fld_q, fld_d;      // captured codeword bits [54:14]
  logic [16:0] x_q, x_d;          // reconstructed value
  logic [5:0]  rem_q, rem_d;      // running remainder of the serial divider
  logic [4:0]  bit_q, bit_d;      // dividend bit step, 0..16
  logic [1:0]  mod_q, mod_d;      // 0:61 1:59 2:55 3:53
  logic [3:0]  acc_q, acc_d;      // mismatch flags gathered during CHECK
  logic [15:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        rerr_q, rerr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [8:0]  r257;
  logic [7:0]  r256;
  logic [5:0]  r61, r59, r55, r53;
  logic [5:0]  modulus, rcv, rem_nxt;
  logic        illegal;
  logic        unused_bits;

  // (r256 - r257) mod 257, correcting a borrow by adding 257 back.
  function automatic logic [8:0] crt_k(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] d;
    d = {2'b00, a} - {1'b0, b};
    if (d[9]) d = d + 10'd257;
    return d[8:0];
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [5:0] mod_step(input logic [5:0] r, input logic b,
                                          input logic [5:0] m);
    logic [6:0] t;
    logic [6:0] s;
    t = {r, b};
    s = t - {1'b0, m};
    if (t >= {1'b0, m}) return s[5:0];
    return t[5:0];
  endfunction

  assign r257 = fld_q[40:32];
  assign r256 = fld_q[31:24];
  assign r61  = fld_q[23:18];
  assign r59  = fld_q[17:12];
  assign r55  = fld_q[11:6];
  assign r53  = fld_q[5:0];

  assign illegal = (r257 > 9'd256) | (r61 > 6'd60) | (r59 > 6'd58) |
                   (r55 > 6'd54) | (r53 > 6'd52);

  assign unused_bits = ^{bus.residues_in[63:55], bus.residues_in[13:0]};

  // Select the modulus under test and its received residue.
  always_comb begin
    modulus = 6'd61;
    rcv     = r61;
    case (mod_q)
      2'd1:    begin modulus = 6'd59; rcv = r59; end
      2'd2:    begin modulus = 6'd55; rcv = r55; end
      2'd3:    begin modulus = 6'd53; rcv = r53; end
      default: begin modulus = 6'd61; rcv = r61; end
    endcase
  end

  assign rem_nxt = mod_step(rem_q, x_q[5'd16 - bit_q], modulus);

  // Next-state and datapath updates for each phase of a decode.
  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    x_d     = x_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    mod_d   = mod_q;
    acc_d   = acc_q;
    data_d  = data_q;
    mask_d  = mask_q;
    rerr_d  = rerr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CRT;
          fld_d   = bus.residues_in[54:14];
          rem_d   = '0;
          bit_d   = '0;
          mod_d   = '0;
          acc_d   = '0;
        end
      end
      CRT: begin
        x_d     = {9'd0, r256} + {crt_k(r256, r257), 8'd0};
        state_d = CHECK;
      end
      CHECK: begin
        rem_d = rem_nxt;
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd16) begin
          bit_d = '0;
          rem_d = '0;
          mod_d = mod_q + 2'd1;
          if (rem_nxt != rcv) acc_d[2'd3 - mod_q] = 1'b1;
          if (mod_q == 2'd3) state_d = OUT;
        end
      end
      OUT: begin
        rerr_d  = x_q[16] | illegal;
        data_d  = illegal ? 16'd0 : x_q[15:0];
        mask_d  = acc_q;
        err_d   = x_q[16] | illegal | (|acc_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Working and result registers; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld_q  <= '0;
      x_q    <= '0;
      rem_q  <= '0;
      bit_q  <= '0;
      mod_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      rerr_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fld_q  <= fld_d;
      x_q    <= x_d;
      rem_q  <= rem_d;
      bit_q  <= bit_d;
      mod_q  <= mod_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      mask_q <= mask_d;
      rerr_q <= rerr_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.range_err     = rerr_q;
  assign bus.err_detected  = err_q;
  assign bus.done          = done_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_2nrm.sv
// Directed bench for decoder_2nrm with hand-computed expected results.
module tb_decoder_2nrm;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_2nrm_if dif();
  decoder_2nrm u_dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack(input logic [8:0] a257, input logic [7:0] a256,
                                       input logic [5:0] a61, input logic [5:0] a59,
                                       input logic [5:0] a55, input logic [5:0] a53);
    return {9'd0, a257, a256, a61, a59, a55, a53, 14'd0};
  endfunction

  task automatic launch(input logic [63:0] v);
    @(negedge clk);
    dif.residues_in = v;
    dif.start       = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic decode(input string tag, input logic [63:0] v, input logic [15:0] ed,
                        input logic [3:0] em, input logic er, input logic ee);
    int n;
    launch(v);
    chk({tag, ".busy"}, dif.busy, 1);
    wait_done(n);
    chk({tag, ".lat"}, n, 70);
    chk({tag, ".data"}, dif.data_out, ed);
    chk({tag, ".mask"}, dif.mismatch_mask, em);
    chk({tag, ".rerr"}, dif.range_err, er);
    chk({tag, ".err"}, dif.err_detected, ee);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, dif.done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".hold"}, dif.data_out, ed);
  endtask

  initial begin
    int ndone;
    int at;
    int first;
    int second;
    logic [15:0] cap;

    dif.start       = 1'b0;
    dif.residues_in = '0;
    rst_n           = 1'b0;
    #12;
    chk("rst.data", dif.data_out, 0);
    chk("rst.mask", dif.mismatch_mask, 0);
    chk("rst.rerr", dif.range_err, 0);
    chk("rst.err",  dif.err_detected, 0);
    chk("rst.done", dif.done, 0);
    chk("rst.busy", dif.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    decode("zero",  64'd0,                          16'd0,     4'b0000, 1'b0, 1'b0);
    decode("v1234", pack(206, 210, 14, 54, 24, 15), 16'd1234,  4'b0000, 1'b0, 1'b0);
    decode("vmax",  pack(0, 255, 21, 45, 30, 27),   16'd65535, 4'b0000, 1'b0, 1'b0);
    decode("r59bad", pack(206, 210, 14, 0, 24, 15), 16'd1234,  4'b0100, 1'b0, 1'b1);
    decode("x65536", pack(1, 0, 0, 0, 0, 0),        16'd0,     4'b1111, 1'b1, 1'b1);
    decode("r61ill", pack(0, 0, 61, 0, 0, 0),       16'd0,     4'b1000, 1'b1, 1'b1);

    // Input change and re-pulsed start during a decode.
    launch(pack(206, 210, 14, 54, 24, 15));
    ndone = 0; at = -1; cap = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 5) dif.residues_in = pack(0, 255, 21, 45, 30, 27);
      dif.start = (i == 10);
      @(posedge clk);
      #1;
      if (dif.done) begin
        ndone++;
        if (at < 0) begin
          at  = i;
          cap = dif.data_out;
        end
      end
    end
    dif.start = 1'b0;
    chk("busy.ndone", ndone, 1);
    chk("busy.lat", at, 70);
    chk("busy.data", cap, 16'd1234);

    // Reset in the middle of CHECK.
    launch(pack(206, 210, 14, 0, 24, 15));
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.data", dif.data_out, 0);
    chk("abort.mask", dif.mismatch_mask, 0);
    chk("abort.rerr", dif.range_err, 0);
    chk("abort.err",  dif.err_detected, 0);
    chk("abort.busy", dif.busy, 0);
    chk("abort.done", dif.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) ndone++;
    end
    chk("abort.nodone", ndone, 0);
    decode("after", pack(0, 255, 21, 45, 30, 27), 16'd65535, 4'b0000, 1'b0, 1'b0);

    // start held high: back-to-back decodes.
    @(negedge clk);
    dif.residues_in = pack(206, 210, 14, 54, 24, 15);
    dif.start       = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (second >= 0) break;
    end
    chk("b2b.first", first, 70);
    chk("b2b.period", second - first, 71);
    chk("b2b.data", dif.data_out, 16'd1234);
    dif.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!dif.busy) break;
    end
    chk("b2b.idle", dif.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
